multiplier_sequencer: RTL and testbench
=======================================

# multiplier_sequencer

Multi-cycle unsigned multiplier controller that computes a WIDTH×WIDTH product by time-sharing one `multiplier2x2` partial-product unit. It uses a Start/Busy/Done handshake. Operands are split into 2-bit digits, and one digit pair is multiplied per cycle. Each shifted partial product is added into an accumulator. The block sits between a requesting datapath and the existing `multiplier2x2`, and is the only driver of that unit's inputs.

## Interface
- WIDTH, 8, operand width in bits; must be even and ≥2; D = WIDTH/2 digits per operand
- Clk  input  1  rising-edge clock
- Reset_n  input  1  synchronous, active-low reset
- Start  input  1  request; sampled only when Busy=0
- Multiplicand  input  WIDTH  unsigned operand A; latched on accepted Start
- Multiplier  input  WIDTH  unsigned operand B; latched on accepted Start
- Busy  output  1  high in RUN and DONE states
- Done  output  1  one-cycle pulse; Product valid
- Product  output  2*WIDTH  unsigned A×B; held until next Done

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN when Start=1.
  - Latch A and B.
  - Clear accumulator and step counter n.
- RUN, n = 0..D²−1:
  - Digit a = A[2(n mod D)+1 : 2(n mod D)].
  - Digit b = B[2(n div D)+1 : 2(n div D)].
  - Feed a and b to `multiplier2x2`; result pp is 4 bits.
  - acc ← acc + (pp << 2·((n mod D)+(n div D))).
  - All arithmetic is 2*WIDTH bits wide. The maximum sum equals (2^WIDTH−1)², so no overflow is possible and no carry-out is kept.
- On the last step (n = D²−1):
  - Product ← acc + shifted pp.
  - Go to DONE.
- DONE: Done=1, Busy=1; next state is IDLE unconditionally.
- Start is ignored in RUN and DONE. It is neither queued nor does it restart the operation.
- Operand inputs are don't-care outside the accepting cycle. Changes during RUN have no effect.
- Reset (Reset_n=0 at a rising edge), including mid-operation:
  - State → IDLE; the operation is aborted with no Done.
  - Busy=0, Done=0, Product=0.
  - acc=0, n=0, latched operands=0.
- Zero operands still take the full D² RUN cycles; there is no early termination.

## Timing
- Cycle 0: Start=1 while IDLE, sampled at the rising edge that ends cycle 0.
- Cycles 1..D²: RUN, Busy=1, Done=0.
- Cycle D²+1: DONE, Done=1, Busy=1, Product valid.
- Cycle D²+2: IDLE, Busy=0. A Start here is accepted; this is the earliest back-to-back start.
- Latency from Start to Done is D²+1 cycles, which is 17 for WIDTH=8 and 2 for WIDTH=2.
- Throughput is one product per D²+2 cycles.
- All outputs are registered. Busy, Done and Product change only at rising edges of Clk.
- The `multiplier2x2` path is combinational within a RUN cycle. Its digit-select muxes, the 4-bit multiply and the 2*WIDTH adder form the critical path.

## Structure
- Shared include `multiplier_defs.vh` holds:
  - State encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - The DIGIT_W=2 constant used for digit slicing and shift scaling.
- One sub-module: a single instance of the existing `multiplier2x2`, port order (result, multiplicand, multiplier).
- The step counter is ⌈log2(D²)⌉ bits wide, minimum 1.

## Test plan
- Reset: hold Reset_n=0 for 2 cycles with Start=1 → Busy=0, Done=0, Product=0; no operation starts.
- WIDTH=8, A=255, B=255, Start in cycle 0:
  - Busy=1 in cycles 1–17.
  - Done=1 only in cycle 17, with Product=65025.
  - Busy=0 in cycle 18.
- WIDTH=8, A=13, B=11:
  - Change the operand inputs to 200/200 in cycle 3, and pulse Start in cycle 5.
  - Required: Product=143 at Done (cycle 17), and the cycle-5 Start has no effect.
- WIDTH=8, A=0, B=77 → Done at cycle 17, Product=0. Then Start in cycle 18 with A=16, B=16 → Done at cycle 35, Product=256, and Product=0 held in cycles 18–34.
- WIDTH=8, A=100, B=3:
  - Reset_n=0 in cycle 8 → Busy=0, Product=0 from cycle 9, and no Done.
  - Restart in cycle 10 → Product=300 at cycle 27.
- WIDTH=2: exhaustively run all 16 pairs (0..3 × 0..3) → Done 2 cycles after each Start, Product=A×B (e.g. 3×3=9).

Source files
------------

// File: rtl/multiplier_sequencer_pkg.sv
// Shared definitions for the digit-serial multiplier sequencer: FSM states,
// digit width, and the step-counter sizing helper.
package multiplier_sequencer_pkg;

   localparam int DIGIT_W = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } SeqState;

   // A single-step schedule still needs a one-bit counter to exist.
   function automatic int stepCountWidth(input int steps);
      return (steps > 1) ? $clog2(steps) : 1;
   endfunction

endpackage

// File: rtl/multiplier_sequencer_multiplier2x2.sv
// Existing 2-bit by 2-bit unsigned partial-product unit, purely combinational.
module multiplier2x2 (
   output logic [3:0] result,
   input  logic [1:0] multiplicand,
   input  logic [1:0] multiplier
);

   assign result = {2'b00, multiplicand} * {2'b00, multiplier};

endmodule

// File: rtl/multiplier_sequencer.sv
// Multi-cycle WIDTH x WIDTH unsigned multiplier that walks every digit pair of
// the latched operands through one shared multiplier2x2, one pair per cycle.
module multiplier_sequencer
   import multiplier_sequencer_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               Start,
   input  logic [WIDTH-1:0]   Multiplicand,
   input  logic [WIDTH-1:0]   Multiplier,
   output logic               Busy,
   output logic               Done,
   output logic [2*WIDTH-1:0] Product
);

   localparam int D     = WIDTH / DIGIT_W;
   localparam int STEPS = D * D;
   localparam int CNT_W = stepCountWidth(STEPS);
   localparam int PW    = 2 * WIDTH;

   SeqState             state;
   SeqState             nextState;
   logic [WIDTH-1:0]    aReg;
   logic [WIDTH-1:0]    bReg;
   logic [PW-1:0]       accReg;
   logic [PW-1:0]       productReg;
   logic [PW-1:0]       ppWide;
   logic [PW-1:0]       accSum;
   logic [CNT_W-1:0]    stepCount;
   logic [DIGIT_W-1:0]  aDigit;
   logic [DIGIT_W-1:0]  bDigit;
   logic [3:0]          pp;
   logic                lastStep;
   logic                busyReg;
   logic                doneReg;
   int                  aIdx;
   int                  bIdx;

   // Step n selects digit (n mod D) of A and digit (n div D) of B, then scales
   // their partial product by the combined digit position.
   always_comb begin
      aIdx     = int'(stepCount) % D;
      bIdx     = int'(stepCount) / D;
      aDigit   = DIGIT_W'(aReg >> (aIdx * DIGIT_W));
      bDigit   = DIGIT_W'(bReg >> (bIdx * DIGIT_W));
      ppWide   = PW'(pp) << ((aIdx + bIdx) * DIGIT_W);
      accSum   = accReg + ppWide;
      lastStep = (stepCount == CNT_W'(STEPS - 1));
   end

   multiplier2x2 ppUnit (
      .result       (pp),
      .multiplicand (aDigit),
      .multiplier   (bDigit)
   );

   // Next-state logic: Start only matters in IDLE; DONE lasts exactly one cycle.
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (Start) nextState = RUN;
         RUN:     if (lastStep) nextState = DONE;
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // State register plus Busy/Done flops, decoded from the next state so the
   // outputs come straight off flops.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state   <= IDLE;
         busyReg <= 1'b0;
         doneReg <= 1'b0;
      end else begin
         state   <= nextState;
         busyReg <= (nextState != IDLE);
         doneReg <= (nextState == DONE);
      end
   end

   // Operand capture, accumulation and result hold; Product only moves on the
   // final step so it stays stable for the whole next operation.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         aReg       <= '0;
         bReg       <= '0;
         accReg     <= '0;
         stepCount  <= '0;
         productReg <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (Start) begin
                  aReg      <= Multiplicand;
                  bReg      <= Multiplier;
                  accReg    <= '0;
                  stepCount <= '0;
               end
            end
            RUN: begin
               accReg    <= accSum;
               stepCount <= stepCount + 1'b1;
               if (lastStep) productReg <= accSum;
            end
            default: ;
         endcase
      end
   end

   assign Busy    = busyReg;
   assign Done    = doneReg;
   assign Product = productReg;

endmodule

// File: tb/tb_multiplier_sequencer.sv
// Directed bench for multiplier_sequencer at WIDTH=8 and WIDTH=2, using a
// per-instance scoreboard of expected products and Done cycles.
module tb_multiplier_sequencer;

   typedef struct {
      logic [15:0] product;
      int          doneCycle;
   } ExpEntry;

   logic        clk;
   logic        resetN;
   logic        start8;
   logic [7:0]  mcand8;
   logic [7:0]  mplier8;
   logic        busy8;
   logic        done8;
   logic [15:0] product8;
   logic        start2;
   logic [1:0]  mcand2;
   logic [1:0]  mplier2;
   logic        busy2;
   logic        done2;
   logic [3:0]  product2;

   ExpEntry     q8[$];
   ExpEntry     q2[$];
   logic [15:0] prodModel8;
   logic [15:0] prodModel2;
   int          cycleNum;
   int          checks;
   int          errors;
   bit          monitorOn;

   multiplier_sequencer #(.WIDTH(8)) dut8 (
      .Clk          (clk),
      .Reset_n      (resetN),
      .Start        (start8),
      .Multiplicand (mcand8),
      .Multiplier   (mplier8),
      .Busy         (busy8),
      .Done         (done8),
      .Product      (product8)
   );

   multiplier_sequencer #(.WIDTH(2)) dut2 (
      .Clk          (clk),
      .Reset_n      (resetN),
      .Start        (start2),
      .Multiplicand (mcand2),
      .Multiplier   (mplier2),
      .Busy         (busy2),
      .Done         (done2),
      .Product      (product2)
   );

   // Free-running 10-time-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s cycle=%0d observed=%0d expected=%0d",
                tag, cycleNum, observed, expected);
      end
   endtask

   // Compares both instances against the scoreboard every cycle; an entry is
   // retired in the cycle its Done is due.
   task automatic monitorOutputs();
      bit expDone;
      bit expBusy;
      expDone = (q8.size() > 0) && (q8[0].doneCycle == cycleNum);
      expBusy = (q8.size() > 0) && (cycleNum >= q8[0].doneCycle - 16);
      if (expDone) begin
         prodModel8 = q8[0].product;
         void'(q8.pop_front());
      end
      checkOutput("busy8", 64'(busy8), 64'(expBusy));
      checkOutput("done8", 64'(done8), 64'(expDone));
      checkOutput("product8", 64'(product8), 64'(prodModel8));

      expDone = (q2.size() > 0) && (q2[0].doneCycle == cycleNum);
      expBusy = (q2.size() > 0) && (cycleNum >= q2[0].doneCycle - 1);
      if (expDone) begin
         prodModel2 = q2[0].product;
         void'(q2.pop_front());
      end
      checkOutput("busy2", 64'(busy2), 64'(expBusy));
      checkOutput("done2", 64'(done2), 64'(expDone));
      checkOutput("product2", 64'(product2), 64'(prodModel2));
   endtask

   task automatic tick();
      @(negedge clk);
      if (monitorOn) monitorOutputs();
      @(posedge clk);
      cycleNum++;
      #1;
   endtask

   task automatic applyStimulus8(input bit s, input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      start8  = s;
      mcand8  = a;
      mplier8 = b;
      p = 16'(a) * 16'(b);
      if (s && resetN && q8.size() == 0) q8.push_back('{p, cycleNum + 17});
   endtask

   task automatic applyStimulus2(input bit s, input logic [1:0] a, input logic [1:0] b);
      logic [15:0] p;
      start2  = s;
      mcand2  = a;
      mplier2 = b;
      p = 16'(a) * 16'(b);
      if (s && resetN && q2.size() == 0) q2.push_back('{p, cycleNum + 2});
   endtask

   task automatic waitIdle8();
      for (int i = 0; i < 60 && q8.size() != 0; i++) tick();
      checkOutput("drain8", 64'(q8.size()), 64'd0);
   endtask

   task automatic waitIdle2();
      for (int i = 0; i < 10 && q2.size() != 0; i++) tick();
      checkOutput("drain2", 64'(q2.size()), 64'd0);
   endtask

   task automatic pulseReset();
      resetN = 1'b0;
      tick();
      q8.delete();
      q2.delete();
      prodModel8 = '0;
      prodModel2 = '0;
      resetN = 1'b1;
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      cycleNum   = 0;
      monitorOn  = 1'b0;
      prodModel8 = '0;
      prodModel2 = '0;

      // Reset held for two cycles with Start asserted: nothing may start.
      resetN = 1'b0;
      applyStimulus8(1'b1, 8'd9, 8'd9);
      applyStimulus2(1'b1, 2'd3, 2'd3);
      tick();
      monitorOn = 1'b1;
      tick();
      checkOutput("reset_busy8", 64'(busy8), 64'd0);
      checkOutput("reset_product8", 64'(product8), 64'd0);
      resetN = 1'b1;
      applyStimulus8(1'b0, 8'd0, 8'd0);
      applyStimulus2(1'b0, 2'd0, 2'd0);
      tick();
      tick();

      // 255 x 255: largest product, Busy across all 17 cycles.
      applyStimulus8(1'b1, 8'd255, 8'd255);
      tick();
      applyStimulus8(1'b0, 8'd0, 8'd0);
      waitIdle8();
      checkOutput("max_product8", 64'(product8), 64'd65025);

      // 13 x 11 with operand changes and a stray Start mid-run.
      applyStimulus8(1'b1, 8'd13, 8'd11);
      tick();
      applyStimulus8(1'b0, 8'd13, 8'd11);
      tick();
      tick();
      applyStimulus8(1'b0, 8'd200, 8'd200);
      tick();
      tick();
      applyStimulus8(1'b1, 8'd200, 8'd200);
      tick();
      applyStimulus8(1'b0, 8'd200, 8'd200);
      waitIdle8();
      checkOutput("ignored_start_product8", 64'(product8), 64'd143);

      // Zero operand, then back-to-back start at the earliest idle cycle.
      applyStimulus8(1'b1, 8'd0, 8'd77);
      tick();
      applyStimulus8(1'b0, 8'd0, 8'd0);
      waitIdle8();
      applyStimulus8(1'b1, 8'd16, 8'd16);
      tick();
      applyStimulus8(1'b0, 8'd0, 8'd0);
      waitIdle8();

      // Abort 100 x 3 mid-run with reset, then restart it.
      applyStimulus8(1'b1, 8'd100, 8'd3);
      tick();
      applyStimulus8(1'b0, 8'd0, 8'd0);
      for (int i = 0; i < 7; i++) tick();
      pulseReset();
      tick();
      applyStimulus8(1'b1, 8'd100, 8'd3);
      tick();
      applyStimulus8(1'b0, 8'd0, 8'd0);
      waitIdle8();
      checkOutput("restart_product8", 64'(product8), 64'd300);

      // WIDTH=2: every operand pair, back to back.
      for (int a = 0; a < 4; a++) begin
         for (int b = 0; b < 4; b++) begin
            applyStimulus2(1'b1, 2'(a), 2'(b));
            tick();
            applyStimulus2(1'b0, 2'd0, 2'd0);
            waitIdle2();
         end
      end
      checkOutput("last_product2", 64'(product2), 64'd9);
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
